// File: rtl/sync_down_counter.sv
// Synchronous loadable down counter/timer with terminal-count pulse and
// optional auto-reload. Every state bit updates on the same rising clk edge.
module sync_down_counter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic         en,
    input  logic         auto_reload,
    output logic [N-1:0] Q,
    output logic         tc,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [N-1:0] CNT_ZERO = {N{1'b0}};
    localparam logic [N-1:0] CNT_ONE  = {{(N-1){1'b0}}, 1'b1};

    state_t       state_q, state_d;
    logic [N-1:0] cnt_q, cnt_d;
    logic [N-1:0] reload_q, reload_d;
    logic         tc_q, tc_d;

    // State, count, reload value and tc pulse registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= CNT_ZERO;
            reload_q <= CNT_ZERO;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    // Next-state logic; priority is load > terminal count > decrement > hold
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        reload_d = reload_q;
        tc_d     = 1'b0;
        if (load) begin
            cnt_d    = load_val;
            reload_d = load_val;
            if (load_val != CNT_ZERO) begin
                state_d = ST_RUN;
            end else begin
                state_d = ST_IDLE;
            end
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (en) begin
                        if (cnt_q == CNT_ONE) begin
                            // auto_reload only matters on this terminal edge
                            tc_d = 1'b1;
                            if (auto_reload) begin
                                cnt_d = reload_q;
                            end else begin
                                cnt_d   = CNT_ZERO;
                                state_d = ST_DONE;
                            end
                        end else if (cnt_q > CNT_ONE) begin
                            cnt_d = cnt_q - CNT_ONE;
                        end else begin
                            // Zero count in RUN is unreachable; never wrap
                            state_d = ST_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end
            endcase
        end
    end

    // Outputs come straight from registers
    always_comb begin
        Q    = cnt_q;
        tc   = tc_q;
        busy = (state_q == ST_RUN);
        done = (state_q == ST_DONE);
    end

endmodule
